// File: rtl/muldiv4_iter_engine_if.sv
// -----------------------------------------------------------------------------
// muldiv4_iter_engine_if
// Request/response bundle for the iterative multiply/divide engine.
//
//   start        master -> slave  request; operands and op sampled on accept
//   op           master -> slave  0 = multiply, 1 = divide
//   a            master -> slave  multiplicand / dividend (WIDTH bits)
//   b            master -> slave  multiplier / divisor   (WIDTH bits)
//   busy         slave -> master  high while iterating
//   done         slave -> master  one-cycle pulse when result becomes valid
//   result       slave -> master  mul: product; div: {remainder, quotient}
//   div_by_zero  slave -> master  divide with b = 0; held with result
// -----------------------------------------------------------------------------
interface muldiv4_iter_engine_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/muldiv4_iter_engine.sv
// -----------------------------------------------------------------------------
// muldiv4_iter_engine
// Iterative unsigned multiply / restoring divide, one bit per clock.
// Multiply: shift-and-add, multiplier consumed LSB first, product accumulated
// in a 2*WIDTH accumulator. Divide: restoring division, dividend consumed MSB
// first, WIDTH+1 bit trial subtraction to detect borrow.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    slave side of muldiv4_iter_engine_if (start/op/a/b in,
//          busy/done/result/div_by_zero out)
//
// Timing: start accepted at edge E0 -> busy for WIDTH cycles -> done for one
// cycle after edge E(WIDTH). result/div_by_zero hold until the next accept.
// -----------------------------------------------------------------------------
module muldiv4_iter_engine #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  muldiv4_iter_engine_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_op;
  logic [WIDTH-1:0]     r_a;       // multiplicand
  logic [WIDTH-1:0]     r_b;       // divisor (kept intact for compare / dbz)
  logic [WIDTH-1:0]     r_mpl;     // multiplier, shifted right each iteration
  logic [WIDTH-1:0]     r_dvd;     // dividend, shifted left each iteration
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_pp;
  logic [2*WIDTH-1:0]   w_pp_ext;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic                 w_take;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;

  // A request is taken in IDLE, or in DONE for back-to-back operation.
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: w_state_next = bus.start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply datapath: AND-gate array broadcasting the current multiplier bit
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign w_pp[gi] = r_a[gi] & r_mpl[0];
    end
  endgenerate

  assign w_pp_ext   = {{WIDTH{1'b0}}, w_pp};
  assign w_acc_next = r_acc + (w_pp_ext << r_cnt);

  // ---------------------------------------------------------------------------
  // Divide datapath. Before iteration i the partial remainder is below 2^i,
  // so its MSB is always zero when shifted; keeping the full register in the
  // WIDTH+1 bit trial value loses nothing and needs no truncation.
  // ---------------------------------------------------------------------------
  assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_take     = ~w_diff[WIDTH];   // no borrow -> rem >= divisor
  assign w_rem_next = w_take ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_take};

  // ---------------------------------------------------------------------------
  // Operand / iteration / result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_mpl    <= '0;
      r_dvd    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_op     <= bus.op;
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_mpl    <= bus.b;
      r_dvd    <= bus.a;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (!r_op) begin
        r_acc <= w_acc_next;
        r_mpl <= r_mpl >> 1;
      end else begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_dvd <= r_dvd << 1;
      end
      if (w_last) begin
        r_result <= r_op ? {w_rem_next, w_quo_next} : w_acc_next;
        // Divide by zero runs the normal iterations (quotient all ones,
        // remainder = dividend); only the flag marks it.
        r_dbz    <= r_op && (r_b == '0);
      end
    end
  end

  assign bus.busy        = (r_state == ST_RUN);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv4_iter_engine.sv
// -----------------------------------------------------------------------------
// tb_muldiv4_iter_engine
// Directed bench for muldiv4_iter_engine. Expected results come from a small
// arithmetic model and are queued when a request is driven, then popped and
// compared when done is seen. DUT outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv4_iter_engine;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;

  muldiv4_iter_engine_if #(.WIDTH(WIDTH)) bus ();

  muldiv4_iter_engine #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {div_by_zero, result}
  logic [2*WIDTH:0] sb[$];
  logic [2*WIDTH:0] last_exp;

  function automatic logic [2*WIDTH:0] model(input logic op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] r;
    logic               z;
    z = 1'b0;
    if (!op) begin
      r = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    end else if (b == 0) begin
      r = {a, {WIDTH{1'b1}}};
      z = 1'b1;
    end else begin
      r = {a % b, a / b};
    end
    return {z, r};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(model(op, a, b));
  endtask

  // Call right after driving start at a falling edge. Returns at the falling
  // edge where done is observed (or after the cycle budget expires).
  task automatic wait_done(input bit mid_pulse);
    int               cyc;
    bit               seen;
    logic [2*WIDTH:0] e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        chk("clear_result", int'(bus.result), 0);
        chk("clear_dbz", int'(bus.div_by_zero), 0);
      end
      if (mid_pulse && cyc == 2) begin
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 4'd5;
        bus.b     = 4'd5;
      end
      if (mid_pulse && cyc == 3) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else chk("busy_while_run", int'(bus.busy), 1);
    end
    chk("latency", cyc, WIDTH + 1);
    if (seen) begin
      chk("done_busy_low", int'(bus.busy), 0);
      chk("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        last_exp = e;
        chk("result", int'(bus.result), int'(e[2*WIDTH-1:0]));
        chk("div_by_zero", int'(bus.div_by_zero), int'(e[2*WIDTH]));
        $display("txn result=0x%02h dbz=%0b expected=0x%02h dbz=%0b",
                 bus.result, bus.div_by_zero, e[2*WIDTH-1:0], e[2*WIDTH]);
      end
    end
  endtask

  task automatic held();
    @(negedge clk);
    chk("done_single_pulse", int'(bus.done), 0);
    chk("held_result", int'(bus.result), int'(last_exp[2*WIDTH-1:0]));
    chk("held_dbz", int'(bus.div_by_zero), int'(last_exp[2*WIDTH]));
  endtask

  task automatic run(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    drive(op, a, b);
    wait_done(1'b0);
    held();
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    last_exp  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_dbz", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply
    run(1'b0, 4'd13, 4'd11);
    run(1'b0, 4'd15, 4'd15);
    run(1'b0, 4'd0, 4'd9);

    // Divide, including divide by zero; the following start clears the flag
    run(1'b1, 4'd13, 4'd3);
    run(1'b1, 4'd15, 4'd15);
    run(1'b1, 4'd7, 4'd0);
    run(1'b1, 4'd9, 4'd10);

    // Start during busy is ignored; start held in DONE is accepted
    @(negedge clk);
    drive(1'b0, 4'd2, 4'd3);
    wait_done(1'b1);
    drive(1'b0, 4'd4, 4'd4);
    wait_done(1'b0);
    held();

    // Reset in the middle of 9*9
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 4'd9;
    bus.b     = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_result", int'(bus.result), 0);
    chk("midrst_dbz", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_done", int'(bus.done), 0);
    end
    run(1'b0, 4'd9, 4'd9);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
